peripheral_bus: RTL and testbench

Memory-mapped peripheral block sitting directly downstream of the single-cycle CPU's data port, in parallel with the data memory. It decodes the CPU's data address, read enable and write enable onto a 32-bit reload timer with interrupt, an 8-bit LED register and a 4-digit multiplexed seven-segment display. It returns read data that the top level muxes into the CPU's memory-read path.

---
 rtl/peripheral_bus.sv | 185 ++++++++++++++++++
 tb/tb_peripheral_bus.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED register and 4-digit seven-segment
// display on the CPU data port; optional SYSTICK via PERIPHERAL_SYSTICK_EN.
//
// Ports:
//   clk, reset     system clock, async active-high reset
//   addr, wdata    CPU data address and store data
//   rd, wr         load / store strobes
//   rdata          combinational read data (0 when not reading a mapped reg)
//   irq            timer interrupt request (IS & IE)
//   led            LED register
//   an, seg        active-low digit anodes and segments {dp,g,f,e,d,c,b,a}
module peripheral_bus #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  led,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGI = 32'h4000_0010;
`ifdef PERIPHERAL_SYSTICK_EN
    localparam logic [31:0] ADDR_TICK = 32'h4000_0014;
`endif

    logic [31:0] th;
    logic [31:0] tl;
    logic        en;
    logic        ie;
    logic        is;
    logic [7:0]  led_q;
    logic [15:0] digi;
    logic [15:0] scan_cnt;
    logic [1:0]  idx;
`ifdef PERIPHERAL_SYSTICK_EN
    logic [31:0] systick;
`endif

    logic we_th;
    logic we_tl;
    logic we_tcon;
    logic we_led;
    logic we_digi;

    assign we_th   = wr && (addr == ADDR_TH);
    assign we_tl   = wr && (addr == ADDR_TL);
    assign we_tcon = wr && (addr == ADDR_TCON);
    assign we_led  = wr && (addr == ADDR_LED);
    assign we_digi = wr && (addr == ADDR_DIGI);

    // A TCON write governs the edge that carries it, so clearing EN
    // suppresses that edge's increment and setting EN counts on it.
    logic run;
    logic ie_now;
    logic ovf;

    assign run    = we_tcon ? wdata[0] : en;
    assign ie_now = we_tcon ? wdata[1] : ie;
    assign ovf    = run && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th       <= '0;
            tl       <= '0;
            en       <= 1'b0;
            ie       <= 1'b0;
            is       <= 1'b0;
            led_q    <= '0;
            digi     <= '0;
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            if (we_th) th <= wdata;

            // CPU write to TL beats increment and reload.
            if (we_tl)
                tl <= wdata;
            else if (ovf)
                tl <= th;
            else if (run)
                tl <= tl + 32'd1;

            if (we_tcon) begin
                en <= wdata[0];
                ie <= wdata[1];
            end

            // Overflow set beats a software clear so no interrupt is lost.
            if (ovf && ie_now)
                is <= 1'b1;
            else if (we_tcon && !wdata[2])
                is <= 1'b0;

            if (we_led)  led_q <= wdata[7:0];
            if (we_digi) digi  <= wdata[15:0];

            if (scan_cnt == SCAN_DIV - 16'd1) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
        end
    end

`ifdef PERIPHERAL_SYSTICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            systick <= '0;
        else
            systick <= systick + 32'd1;
    end
`endif

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                ADDR_TH:   rdata = th;
                ADDR_TL:   rdata = tl;
                ADDR_TCON: rdata = {29'd0, is, ie, en};
                ADDR_LED:  rdata = {24'd0, led_q};
                ADDR_DIGI: rdata = {16'd0, digi};
`ifdef PERIPHERAL_SYSTICK_EN
                ADDR_TICK: rdata = systick;
`endif
                default:   rdata = '0;
            endcase
        end
    end

    assign irq = is && ie;
    assign led = led_q;

    // Active-high glyphs {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hexdecode(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [3:0] nibble;

    always_comb begin
        nibble = digi[3:0];
        case (idx)
            2'd0:    nibble = digi[3:0];
            2'd1:    nibble = digi[7:4];
            2'd2:    nibble = digi[11:8];
            default: nibble = digi[15:12];
        endcase
    end

    assign an  = ~(4'b0001 << idx);
    assign seg = {1'b1, ~hexdecode(nibble)};

endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: directed self-checking bench for peripheral_bus
// (SCAN_DIV overridden to 4 to keep display scanning short).
module tb_peripheral_bus;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  led;
    logic [3:0]  an;
    logic [7:0]  seg;

    peripheral_bus #(.SCAN_DIV(16'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .rd    (rd),
        .wr    (wr),
        .rdata (rdata),
        .irq   (irq),
        .led   (led),
        .an    (an),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;
    localparam logic [31:0] A_BAD  = 32'h4000_0018;

    int passed;
    int total;

    typedef struct {
        string       name;
        logic        do_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drives a one-cycle store; returns 1 time unit after the write edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr    = 1'b0;
        wdata = '0;
    endtask

    // Combinational read at the current time (kept away from edges by callers).
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = rdata;
        rd   = 1'b0;
    endtask

    logic [31:0] r;
    logic [31:0] r2;
    logic [3:0]  prev_an;
    logic [7:0]  exp_seg[4];
    logic [3:0]  exp_an[4];
    bit          found;

    initial begin
        passed = 0;
        total  = 0;
        addr   = '0;
        wdata  = '0;
        rd     = 1'b0;
        wr     = 1'b0;
        reset  = 1'b1;

        vecs[0] = '{"th_rw",     1'b1, A_TH,   32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{"tl_rw",     1'b1, A_TL,   32'h9ABC_DEF0, 32'h9ABC_DEF0};
        vecs[2] = '{"tcon_is1",  1'b1, A_TCON, 32'hFFFF_FFFC, 32'h0};
        vecs[3] = '{"led_rw",    1'b1, A_LED,  32'h1234_56A5, 32'h0000_00A5};
        vecs[4] = '{"digi_rw",   1'b1, A_DIGI, 32'hABCD_1234, 32'h0000_1234};
        vecs[5] = '{"unmapped",  1'b1, A_BAD,  32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{"th_keep",   1'b0, A_TH,   32'h0,         32'h1234_5678};
        vecs[7] = '{"led_keep",  1'b0, A_LED,  32'h0,         32'h0000_00A5};

        #2;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_an",  {28'd0, an},  32'hE);
        check("rst_seg", {24'd0, seg}, 32'hC0);
        bus_read(A_TH,   r); check("rst_th",   r, 32'd0);
        bus_read(A_TL,   r); check("rst_tl",   r, 32'd0);
        bus_read(A_TCON, r); check("rst_tcon", r, 32'd0);
        bus_read(A_LED,  r); check("rst_ledr", r, 32'd0);
        bus_read(A_DIGI, r); check("rst_digi", r, 32'd0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr)
                bus_write(vecs[i].a, vecs[i].d);
            bus_read(vecs[i].a, r);
            check(vecs[i].name, r, vecs[i].exp);
        end
        check("led_pin", {24'd0, led}, 32'hA5);
        addr = A_TH;
        #1;
        check("rd_low", rdata, 32'd0);

        // Overflow: EN takes effect on the TCON write edge, reload one edge later.
        bus_write(A_TH,   32'hFFFF_FFF0);
        bus_write(A_TL,   32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        bus_read(A_TL, r);
        check("tl_ffff", r, 32'hFFFF_FFFF);
        check("irq_pre", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        bus_read(A_TL, r);   check("tl_reload", r, 32'hFFFF_FFF0);
        bus_read(A_TCON, r); check("tcon_is",   r, 32'h7);
        check("irq_set", {31'd0, irq}, 32'd1);
        bus_write(A_TCON, 32'h3);
        bus_read(A_TCON, r); check("tcon_clr", r, 32'h3);
        check("irq_clr", {31'd0, irq}, 32'd0);

        // Stop, park TL at all-ones, then clear IS on the overflow edge.
        bus_write(A_TCON, 32'h0);
        bus_write(A_TL,   32'hFFFF_FFFF);
        bus_read(A_TL, r);   check("tl_hold", r, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h3);
        bus_read(A_TCON, r); check("set_wins", r, 32'h7);
        bus_read(A_TL, r);   check("tl_rl2",   r, 32'hFFFF_FFF0);
        check("irq_sw", {31'd0, irq}, 32'd1);

        // TL write beats increment; counting continues afterwards.
        bus_write(A_TL, 32'h5);
        bus_read(A_TL, r); check("tl_wr_win", r, 32'h5);
        @(posedge clk);
        #1;
        bus_read(A_TL, r); check("tl_inc", r, 32'h6);

        // Disabling on the next edge must not increment on that edge.
        bus_write(A_TL,   32'd100);
        bus_write(A_TCON, 32'h2);
        bus_read(A_TL, r); check("en_off", r, 32'd100);
        repeat (3) @(posedge clk);
        #1;
        bus_read(A_TL, r);   check("en_hold",  r, 32'd100);
        bus_read(A_TCON, r); check("tcon_ie",  r, 32'h2);
        check("irq_off", {31'd0, irq}, 32'd0);

        // Display scan.
        exp_seg[0] = 8'h8E; exp_an[0] = 4'b1110;
        exp_seg[1] = 8'hB0; exp_an[1] = 4'b1101;
        exp_seg[2] = 8'h88; exp_an[2] = 4'b1011;
        exp_seg[3] = 8'hF9; exp_an[3] = 4'b0111;
        bus_write(A_DIGI, 32'h0000_1A3F);
        found   = 1'b0;
        prev_an = an;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev_an == 4'b0111)
                found = 1'b1;
            prev_an = an;
        end
        check("scan_sync", {31'd0, found}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k != 0)
                repeat (4) @(negedge clk);
            check($sformatf("an_%0d", k),  {28'd0, an},  {28'd0, exp_an[k]});
            check($sformatf("seg_%0d", k), {24'd0, seg}, {24'd0, exp_seg[k]});
        end

        // SYSTICK.
        @(posedge clk);
        #1;
`ifdef PERIPHERAL_SYSTICK_EN
        bus_read(A_TICK, r);
        repeat (10) @(posedge clk);
        #1;
        bus_read(A_TICK, r2);
        check("systick_d", r2 - r, 32'd10);
`else
        bus_read(A_TICK, r);
        check("systick_0", r, 32'd0);
        r2 = r;
`endif

        // Asynchronous reset away from any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("arst_led", {24'd0, led}, 32'd0);
        check("arst_an",  {28'd0, an},  32'hE);
        bus_read(A_TH, r);   check("arst_th",   r, 32'd0);
        bus_read(A_TCON, r); check("arst_tcon", r, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
